// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - issue scoreboard and register file write-port controller
// Optional feature macro: SCOREBOARD_FWD_EN (same-cycle writeback bypass).
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2,
  parameter int TOT_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rs1,
  input  logic [4:0]        issue_rs2,
  input  logic              issue_use_rs2,
  input  logic              issue_we,
  input  logic [4:0]        issue_rd,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_rs1,
  output logic              fwd_rs2,
  output logic [TOT_W-1:0]  inflight,
  output logic              sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [TOT_W-1:0] inflight_q, inflight_d;
  logic             sb_err_q, sb_err_d;

  logic wb_fire;
  logic wb_cnt_zero;
  logic dec;
  logic rd_track;
  logic inc;
  logic haz_rs1, haz_rs2, haz_sat;

  // r0 is hardwired, so writebacks to it never reach the register file
  assign wb_fire     = wb_valid && (wb_addr != 5'd0);
  assign wb_cnt_zero = (cnt_q[wb_addr] == '0);
  assign dec         = wb_fire && !wb_cnt_zero;
  assign rd_track    = issue_we && (issue_rd != 5'd0);
  assign inc         = issue_valid && issue_ready && rd_track;

  assign rf_we    = wb_fire;
  assign rf_waddr = wb_addr;
  assign rf_wdata = wb_data;

`ifdef SCOREBOARD_FWD_EN
  // Bypass only when the writeback retires the last outstanding write
  assign fwd_rs1 = wb_fire && (wb_addr == issue_rs1) && (issue_rs1 != 5'd0) &&
                   (cnt_q[issue_rs1] == CNT_ONE);
  assign fwd_rs2 = wb_fire && issue_use_rs2 && (wb_addr == issue_rs2) &&
                   (issue_rs2 != 5'd0) && (cnt_q[issue_rs2] == CNT_ONE);
`else
  assign fwd_rs1 = 1'b0;
  assign fwd_rs2 = 1'b0;
`endif

  assign haz_rs1 = (issue_rs1 != 5'd0) && (cnt_q[issue_rs1] != '0) && !fwd_rs1;
  assign haz_rs2 = issue_use_rs2 && (issue_rs2 != 5'd0) &&
                   (cnt_q[issue_rs2] != '0) && !fwd_rs2;
  // A full counter may still accept when a writeback frees a slot this cycle
  assign haz_sat = rd_track && (cnt_q[issue_rd] == CNT_MAX) &&
                   !(wb_fire && (wb_addr == issue_rd));

  assign issue_ready = rst_n && !haz_rs1 && !haz_rs2 && !haz_sat;

  assign inflight = inflight_q;
  assign sb_err   = sb_err_q;

  // Next-state for per-register counters, total count and the sticky error
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    for (int i = 1; i < 32; i++) begin
      case ({inc && (issue_rd == 5'(i)), dec && (wb_addr == 5'(i))})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
    cnt_d[0] = '0;

    inflight_d = inflight_q;
    if (inc && !dec) begin
      inflight_d = inflight_q + TOT_W'(1);
    end else if (dec && !inc) begin
      inflight_d = inflight_q - TOT_W'(1);
    end

    sb_err_d = sb_err_q || (wb_fire && wb_cnt_zero);
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= '0;
      end
      inflight_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      inflight_q <= inflight_d;
      sb_err_q   <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_use_rs2, issue_we;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_rs1, fwd_rs2;
  logic [6:0]  inflight;
  logic        sb_err;

  int passed = 0;
  int total  = 0;

`ifdef SCOREBOARD_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs2(issue_use_rs2), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .inflight(inflight), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic use2, input logic we, input logic [4:0] rd);
    issue_valid = v; issue_rs1 = rs1; issue_rs2 = rs2;
    issue_use_rs2 = use2; issue_we = we; issue_rd = rd;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid = v; wb_addr = a; wb_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    set_issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    set_wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("reset_ready", issue_ready, 0);
    chk("reset_inflight", inflight, 0);
    chk("reset_sb_err", sb_err, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;

    // Basic RAW stall on r5
    set_issue(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 5'd5);
    #1 chk("raw_first_ready", issue_ready, 1);
    tick();
    chk("raw_inflight1", inflight, 1);
    set_issue(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0);
    #1 chk("raw_stall", issue_ready, 0);
    tick();
    chk("raw_stall_hold", issue_ready, 0);
    set_wb(1'b1, 5'd5, 32'h1234);
    #1;
    chk("raw_rf_we", rf_we, 1);
    chk("raw_rf_waddr", rf_waddr, 5);
    chk("raw_rf_wdata", rf_wdata, 32'h1234);
    chk("raw_wb_ready", issue_ready, FWD);
    chk("raw_fwd_rs1", fwd_rs1, FWD);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("raw_after_ready", issue_ready, 1);
    chk("raw_after_fwd", fwd_rs1, 0);
    chk("raw_inflight0", inflight, 0);

    // rs2 hazard depends on issue_use_rs2
    set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3);
    tick();
    set_issue(1'b1, 5'd0, 5'd3, 1'b0, 1'b0, 5'd0);
    #1 chk("rs2_unused_ready", issue_ready, 1);
    issue_valid = 1'b0;
    issue_use_rs2 = 1'b1;
    #1 chk("rs2_used_stall", issue_ready, 0);
    set_wb(1'b1, 5'd3, 32'hA5);
    #1;
    chk("rs2_wb_ready", issue_ready, FWD);
    chk("rs2_fwd", fwd_rs2, FWD);
    chk("rs2_fwd_rs1_quiet", fwd_rs1, 0);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    #1 chk("rs2_after_ready", issue_ready, 1);

    // Register 0 is never tracked or written
    set_issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0);
    #1 chk("r0_ready", issue_ready, 1);
    tick();
    chk("r0_inflight", inflight, 0);
    issue_valid = 1'b0;
    set_wb(1'b1, 5'd0, 32'hDEAD);
    #1 chk("r0_rf_we", rf_we, 0);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("r0_sb_err", sb_err, 0);
    chk("r0_inflight_after", inflight, 0);

    // Saturation on r7
    set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7);
    for (int i = 0; i < 3; i++) begin
      #1 chk("sat_fill_ready", issue_ready, 1);
      tick();
    end
    chk("sat_inflight3", inflight, 3);
    chk("sat_full_stall", issue_ready, 0);
    tick();
    chk("sat_stall_inflight", inflight, 3);
    set_wb(1'b1, 5'd7, 32'h7);
    #1 chk("sat_wb_ready", issue_ready, 1);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("sat_swap_inflight", inflight, 3);
    chk("sat_still_full", issue_ready, 0);
    issue_valid = 1'b0;
    set_wb(1'b1, 5'd7, 32'h7);
    tick(); chk("sat_drain2", inflight, 2);
    tick(); chk("sat_drain1", inflight, 1);
    tick(); chk("sat_drain0", inflight, 0);
    set_wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("sat_drain_sb_err", sb_err, 0);
    chk("sat_empty_ready", issue_ready, 1);

    // Simultaneous issue and writeback on r9
    set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9);
    tick();
    chk("sim_inflight1", inflight, 1);
    set_wb(1'b1, 5'd9, 32'h99);
    #1 chk("sim_ready", issue_ready, 1);
    tick();
    chk("sim_inflight_same", inflight, 1);
    issue_valid = 1'b0;
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("sim_drained", inflight, 0);
    chk("sim_sb_err", sb_err, 0);

    // Spurious writeback to r12
    set_wb(1'b1, 5'd12, 32'hC);
    #1;
    chk("spur_rf_we", rf_we, 1);
    chk("spur_rf_waddr", rf_waddr, 12);
    chk("spur_sb_err_before", sb_err, 0);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    #1;
    chk("spur_sb_err_set", sb_err, 1);
    chk("spur_inflight", inflight, 0);
    set_issue(1'b0, 5'd12, 5'd0, 1'b0, 1'b0, 5'd0);
    #1 chk("spur_cnt_zero", issue_ready, 1);
    tick(); tick();
    chk("spur_sb_err_sticky", sb_err, 1);

    // Asynchronous reset in the middle of traffic, with r5 pending twice
    set_issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5);
    tick(); tick();
    chk("rst_pre_inflight", inflight, 2);
    issue_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_inflight", inflight, 0);
    chk("rst_async_sb_err", sb_err, 0);
    chk("rst_async_ready", issue_ready, 0);
    tick();
    rst_n = 1'b1;
    set_issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5);
    #1;
    chk("rst_release_ready", issue_ready, 1);
    chk("rst_release_inflight", inflight, 0);
    chk("rst_release_sb_err", sb_err, 0);
    issue_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
